// File: rtl/fetch_unit_pkg.sv
// Shared front-end constants used by the pipeline stages: the canonical NOP encoding,
// the default boot address and the sequential fetch stride.
package fetch_unit_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NopInstr = 32'h0000_0013;

    localparam logic [31:0] DefaultResetVector = 32'h0000_0000;

    localparam int unsigned PcStep = 4;

endpackage

// File: rtl/fetch_queue.sv
// Circular-buffer FIFO with a single-cycle flush and an occupancy count.
// Depth must be a power of two so the pointers wrap naturally.
module fetch_queue #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [Width-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic                   head_valid_o,
    output logic [Width-1:0]       head_data_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    logic empty;
    logic full;
    logic do_push;
    logic do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(Depth));

    // Flush wins over both ports; a pop at full frees the slot for a same-cycle push.
    assign do_pop  = pop_i && !empty && !flush_i;
    assign do_push = push_i && !flush_i && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_valid_o = !empty;
    assign head_data_o  = mem_q[rd_ptr_q];
    assign count_o      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC generation, credit-based request issue to a
// one-cycle-latency instruction memory, and a decoupling queue towards decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(DefaultResetVector),
    parameter int unsigned      FQ_DEPTH     = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      redirect_valid_i,
    input  logic [XLEN-1:0]           redirect_pc_i,
    output logic                      imem_req_valid_o,
    output logic [XLEN-1:0]           imem_addr_o,
    input  logic [31:0]               imem_instr_i,
    output logic                      dec_valid_o,
    output logic [XLEN-1:0]           dec_pc_o,
    output logic [31:0]               dec_instr_o,
    input  logic                      dec_ready_i,
    output logic [$clog2(FQ_DEPTH):0] fq_count_o
);

    localparam int unsigned CntW = $clog2(FQ_DEPTH) + 1;
    localparam int unsigned EntW = XLEN + 32;

    logic            active_q;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

    logic [CntW-1:0] fq_count;
    logic [CntW:0]   credits_used;
    logic            credit_ok;
    logic            req;
    logic            push;
    logic            pop;
    logic            head_valid;
    logic [EntW-1:0] head_data;
    logic [XLEN-1:0] redirect_target;
    logic            unused_redirect_lsb;

    assign redirect_target     = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    // Queued entries plus the outstanding response must fit, so the queue cannot overflow.
    assign credits_used = {1'b0, fq_count} + {{CntW{1'b0}}, inflight_q};
    assign credit_ok    = (credits_used < (CntW + 1)'(FQ_DEPTH));

    // active_q keeps the request line quiet while reset is held.
    assign req  = active_q && !redirect_valid_i && credit_ok;
    assign push = inflight_q && !redirect_valid_i;
    assign pop  = dec_ready_i && head_valid;

    always_comb begin
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = req;
        if (redirect_valid_i) begin
            pc_d = redirect_target;
        end else if (req) begin
            pc_d          = pc_q + XLEN'(PcStep);
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q      <= 1'b0;
            pc_q          <= RESET_VECTOR;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            active_q      <= 1'b1;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_queue #(
        .Width (EntW),
        .Depth (FQ_DEPTH)
    ) u_fetch_queue (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (redirect_valid_i),
        .push_i       (push),
        .push_data_i  ({inflight_pc_q, imem_instr_i}),
        .pop_i        (pop),
        .head_valid_o (head_valid),
        .head_data_o  (head_data),
        .count_o      (fq_count)
    );

    always_comb begin
        imem_req_valid_o = req;
        imem_addr_o      = pc_q;
        dec_valid_o      = head_valid;
        dec_pc_o         = '0;
        dec_instr_o      = NopInstr;
        if (head_valid) begin
            dec_pc_o    = head_data[EntW-1:32];
            dec_instr_o = head_data[31:0];
        end
        fq_count_o = fq_count;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a default-parameter instance for the main scenarios and a
// second instance booting near the top of the address space for PC wrap.
module tb_fetch_unit;

    localparam logic [31:0] Nop  = 32'h0000_0013;
    localparam logic [31:0] Salt = 32'h1234_0000;

    logic        clk;
    logic        rst_n, rst2_n;
    logic        redirect_valid, redirect2_valid;
    logic [31:0] redirect_pc, redirect2_pc;
    logic        imem_req_valid, imem2_req_valid;
    logic [31:0] imem_addr, imem2_addr;
    logic [31:0] imem_instr, imem2_instr;
    logic        dec_valid, dec2_valid;
    logic [31:0] dec_pc, dec2_pc;
    logic [31:0] dec_instr, dec2_instr;
    logic        dec_ready, dec2_ready;
    logic [2:0]  fq_count, fq2_count;

    int n_vec = 0;
    int n_err = 0;

    fetch_unit u_dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .imem_req_valid_o (imem_req_valid),
        .imem_addr_o      (imem_addr),
        .imem_instr_i     (imem_instr),
        .dec_valid_o      (dec_valid),
        .dec_pc_o         (dec_pc),
        .dec_instr_o      (dec_instr),
        .dec_ready_i      (dec_ready),
        .fq_count_o       (fq_count)
    );

    fetch_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'hFFFF_FFF8),
        .FQ_DEPTH     (4)
    ) u_dut_wrap (
        .clk_i            (clk),
        .rst_ni           (rst2_n),
        .redirect_valid_i (redirect2_valid),
        .redirect_pc_i    (redirect2_pc),
        .imem_req_valid_o (imem2_req_valid),
        .imem_addr_o      (imem2_addr),
        .imem_instr_i     (imem2_instr),
        .dec_valid_o      (dec2_valid),
        .dec_pc_o         (dec2_pc),
        .dec_instr_o      (dec2_instr),
        .dec_ready_i      (dec2_ready),
        .fq_count_o       (fq2_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memories: answer one cycle after the request with an address-derived word.
    always @(posedge clk) begin
        imem_instr  <= imem_req_valid  ? (imem_addr ^ Salt)  : 32'hDEAD_BEEF;
        imem2_instr <= imem2_req_valid ? (imem2_addr ^ Salt) : 32'hDEAD_BEEF;
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n          = 1'b0;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        next_cycle();
        #1;
        n_vec++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imem_req_valid); end
        n_vec++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL reset_dec_valid: got %b want 0", dec_valid); end
        n_vec++; if (dec_pc !== 32'h0) begin n_err++; $display("FAIL reset_dec_pc: got %h want 0", dec_pc); end
        n_vec++; if (dec_instr !== Nop) begin n_err++; $display("FAIL reset_dec_instr: got %h want %h", dec_instr, Nop); end
        n_vec++; if (fq_count !== 3'd0) begin n_err++; $display("FAIL reset_fq_count: got %0d want 0", fq_count); end
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        n_vec++; if (imem2_addr !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL reset_vector2: got %h want fffffff8", imem2_addr); end
        n_vec++; if (imem2_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req2: got %b want 0", imem2_req_valid); end
    endtask

    task automatic test_latency;
        do_reset();
        dec_ready = 1'b1;
        next_cycle(); #1;
        n_vec++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL lat_first_req: got %b/%h want 1/0", imem_req_valid, imem_addr); end
        n_vec++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL lat_c1_dec_valid: got %b want 0", dec_valid); end
        next_cycle(); #1;
        n_vec++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h4) begin n_err++; $display("FAIL lat_second_req: got %b/%h want 1/4", imem_req_valid, imem_addr); end
        n_vec++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL lat_c2_dec_valid: got %b want 0", dec_valid); end
        for (int i = 0; i < 5; i++) begin
            next_cycle(); #1;
            n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 32'(4 * i)) begin n_err++; $display("FAIL stream_pc[%0d]: got %b/%h want 1/%h", i, dec_valid, dec_pc, 32'(4 * i)); end
            n_vec++; if (dec_instr !== (32'(4 * i) ^ Salt)) begin n_err++; $display("FAIL stream_instr[%0d]: got %h want %h", i, dec_instr, 32'(4 * i) ^ Salt); end
            n_vec++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'(8 + 4 * i)) begin n_err++; $display("FAIL stream_req[%0d]: got %b/%h want 1/%h", i, imem_req_valid, imem_addr, 32'(8 + 4 * i)); end
        end
    endtask

    task automatic test_stall;
        do_reset();
        repeat (5) next_cycle();
        for (int c = 6; c <= 10; c++) begin
            next_cycle(); #1;
            n_vec++; if (fq_count !== 3'd4) begin n_err++; $display("FAIL stall_count[c%0d]: got %0d want 4", c, fq_count); end
            n_vec++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL stall_req[c%0d]: got %b want 0", c, imem_req_valid); end
            n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_instr !== Salt) begin n_err++; $display("FAIL stall_head[c%0d]: got %b/%h/%h want 1/0/%h", c, dec_valid, dec_pc, dec_instr, Salt); end
        end
        next_cycle();
        dec_ready = 1'b1;
        #1;
        n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin n_err++; $display("FAIL drain_pc[0]: got %b/%h want 1/0", dec_valid, dec_pc); end
        for (int i = 1; i <= 4; i++) begin
            next_cycle(); #1;
            n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 32'(4 * i)) begin n_err++; $display("FAIL drain_pc[%0d]: got %b/%h want 1/%h", i, dec_valid, dec_pc, 32'(4 * i)); end
            if (i == 1) begin
                n_vec++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h10) begin n_err++; $display("FAIL drain_refetch: got %b/%h want 1/10", imem_req_valid, imem_addr); end
            end
        end
    endtask

    task automatic test_redirect_full;
        do_reset();
        repeat (6) next_cycle();
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        n_vec++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL redir_full_req: got %b want 0", imem_req_valid); end
        n_vec++; if (fq_count !== 3'd4) begin n_err++; $display("FAIL redir_full_pre_count: got %0d want 4", fq_count); end
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        n_vec++; if (fq_count !== 3'd0) begin n_err++; $display("FAIL redir_full_count: got %0d want 0", fq_count); end
        n_vec++; if (dec_valid !== 1'b0 || dec_instr !== Nop || dec_pc !== 32'h0) begin n_err++; $display("FAIL redir_full_dec: got %b/%h/%h want 0/0/%h", dec_valid, dec_pc, dec_instr, Nop); end
        n_vec++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL redir_full_target: got %b/%h want 1/100", imem_req_valid, imem_addr); end
        next_cycle(); #1;
        n_vec++; if (imem_addr !== 32'h104 || dec_valid !== 1'b0) begin n_err++; $display("FAIL redir_full_c2: got %h/%b want 104/0", imem_addr, dec_valid); end
        next_cycle(); #1;
        n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 32'h100 || dec_instr !== (32'h100 ^ Salt)) begin n_err++; $display("FAIL redir_full_first: got %b/%h/%h want 1/100/%h", dec_valid, dec_pc, dec_instr, 32'h100 ^ Salt); end
    endtask

    task automatic test_redirect_inflight;
        do_reset();
        repeat (4) next_cycle();
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        #1;
        n_vec++; if (fq_count !== 3'd3 || imem_req_valid !== 1'b0) begin n_err++; $display("FAIL redir_infl_pre: got %0d/%b want 3/0", fq_count, imem_req_valid); end
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        n_vec++; if (fq_count !== 3'd0 || dec_valid !== 1'b0) begin n_err++; $display("FAIL redir_infl_flush: got %0d/%b want 0/0", fq_count, dec_valid); end
        n_vec++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h40) begin n_err++; $display("FAIL redir_infl_target: got %b/%h want 1/40", imem_req_valid, imem_addr); end
        next_cycle(); #1;
        n_vec++; if (fq_count !== 3'd0) begin n_err++; $display("FAIL redir_infl_discard: got %0d want 0", fq_count); end
        next_cycle(); #1;
        n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 32'h40 || dec_instr !== (32'h40 ^ Salt)) begin n_err++; $display("FAIL redir_infl_first: got %b/%h/%h want 1/40/%h", dec_valid, dec_pc, dec_instr, 32'h40 ^ Salt); end
        n_vec++; if (fq_count !== 3'd1) begin n_err++; $display("FAIL redir_infl_count: got %0d want 1", fq_count); end
    endtask

    task automatic test_back_to_back_redirect;
        do_reset();
        dec_ready = 1'b1;
        repeat (4) next_cycle();
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0202;
        #1;
        n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 32'h8 || imem_req_valid !== 1'b0) begin n_err++; $display("FAIL b2b_transfer: got %b/%h/%b want 1/8/0", dec_valid, dec_pc, imem_req_valid); end
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        n_vec++; if (dec_valid !== 1'b0 || fq_count !== 3'd0) begin n_err++; $display("FAIL b2b_flush: got %b/%0d want 0/0", dec_valid, fq_count); end
        n_vec++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin n_err++; $display("FAIL b2b_target: got %b/%h want 1/200", imem_req_valid, imem_addr); end
        next_cycle(); #1;
        n_vec++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL b2b_gap: got %b want 0", dec_valid); end
        for (int i = 0; i < 2; i++) begin
            next_cycle(); #1;
            n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 32'(32'h200 + 4 * i)) begin n_err++; $display("FAIL b2b_pc[%0d]: got %b/%h want 1/%h", i, dec_valid, dec_pc, 32'(32'h200 + 4 * i)); end
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        dec_ready = 1'b1;
        repeat (4) next_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (imem_req_valid !== 1'b0 || imem_addr !== 32'h0) begin n_err++; $display("FAIL arst_req: got %b/%h want 0/0", imem_req_valid, imem_addr); end
        n_vec++; if (dec_valid !== 1'b0 || dec_pc !== 32'h0 || dec_instr !== Nop) begin n_err++; $display("FAIL arst_dec: got %b/%h/%h want 0/0/%h", dec_valid, dec_pc, dec_instr, Nop); end
        n_vec++; if (fq_count !== 3'd0) begin n_err++; $display("FAIL arst_count: got %0d want 0", fq_count); end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle(); #1;
        n_vec++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0 || fq_count !== 3'd0) begin n_err++; $display("FAIL arst_restart: got %b/%h/%0d want 1/0/0", imem_req_valid, imem_addr, fq_count); end
        next_cycle(); #1;
        n_vec++; if (dec_valid !== 1'b0 || fq_count !== 3'd0) begin n_err++; $display("FAIL arst_no_stale: got %b/%0d want 0/0", dec_valid, fq_count); end
        next_cycle(); #1;
        n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin n_err++; $display("FAIL arst_first_dec: got %b/%h want 1/0", dec_valid, dec_pc); end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_addr [4];
        logic [31:0] exp_pc [3];
        exp_addr[0] = 32'hFFFF_FFF8;
        exp_addr[1] = 32'hFFFF_FFFC;
        exp_addr[2] = 32'h0000_0000;
        exp_addr[3] = 32'h0000_0004;
        exp_pc[0]   = 32'hFFFF_FFF8;
        exp_pc[1]   = 32'hFFFF_FFFC;
        exp_pc[2]   = 32'h0000_0000;
        next_cycle();
        rst2_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            next_cycle(); #1;
            if (c <= 4) begin
                n_vec++; if (imem2_req_valid !== 1'b1 || imem2_addr !== exp_addr[c-1]) begin n_err++; $display("FAIL wrap_addr[c%0d]: got %b/%h want 1/%h", c, imem2_req_valid, imem2_addr, exp_addr[c-1]); end
            end
            if (c >= 3) begin
                n_vec++; if (dec2_valid !== 1'b1 || dec2_pc !== exp_pc[c-3]) begin n_err++; $display("FAIL wrap_pc[c%0d]: got %b/%h want 1/%h", c, dec2_valid, dec2_pc, exp_pc[c-3]); end
            end
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        rst2_n          = 1'b0;
        dec_ready       = 1'b0;
        dec2_ready      = 1'b1;
        redirect_valid  = 1'b0;
        redirect2_valid = 1'b0;
        redirect_pc     = 32'h0;
        redirect2_pc    = 32'h0;

        test_reset();
        test_latency();
        test_stall();
        test_redirect_full();
        test_redirect_inflight();
        test_back_to_back_redirect();
        test_async_reset();
        test_wrap();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
